// File: rtl/rl11_dma.sv
// rl11_dma: Unibus NPR bus-master engine moving words between PDP memory and a sector buffer.
// Build option RL11_DMA_BURST_EN: up to 4 words per bus tenure instead of one NPR per word.
module rl11_dma #(
  parameter int         BUFWORDS   = 256,
  parameter logic [7:0] NXMTIMEOUT = 8'd150
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [1:0]  armwaddr,
  input  logic [1:0]  armraddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        init_in_h,
  output logic        npr_out_h,
  input  logic        npg_in_h,
  output logic        sack_out_h,
  input  logic        bbsy_in_h,
  output logic        bbsy_out_h,
  input  logic        ssyn_in_h,
  output logic        msyn_out_h,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h,
  input  logic [15:0] d_in_h,
  output logic        done
);
  localparam int PW = (BUFWORDS > 1) ? $clog2(BUFWORDS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_SACK, S_WAITBUS, S_DESKEW, S_MSYN, S_LATCH, S_END, S_NEXT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d, nxm_q, nxm_d, abort_q, abort_d;
  logic          dir_q, dir_d, abdone_q, abdone_d;
  logic [17:0]   curaddr_q, curaddr_d;
  logic [8:0]    remaining_q, remaining_d;
  logic [PW-1:0] ptr_q, ptr_d, bufidx_q, bufidx_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [15:0]   buf_mem [BUFWORDS];
  logic          drive, last, burst_cont, start, arm_buf_we, latch_we;
  logic [PW-1:0] arm_ptr;
  logic          unused_bits;
`ifdef RL11_DMA_BURST_EN
  logic [1:0]    tenure_q, tenure_d;
`endif

  assign unused_bits = ^armwdata[29:24];
  assign last        = (remaining_q == 9'd1);
  assign start       = armwrite && armwaddr == 2'd1 && armwdata[31] && !busy_q && !init_in_h;
  assign arm_ptr     = armwdata[16 +: PW];
  assign arm_buf_we  = armwrite && armwaddr == 2'd3 && armwdata[31];
  assign latch_we    = (state_q == S_LATCH) && !dir_q;

`ifdef RL11_DMA_BURST_EN
  // tenure_q counts words already moved in the current tenure, minus one
  assign burst_cont = !last && !nxm_q && tenure_q != 2'd3;
`else
  assign burst_cont = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    nxm_d       = nxm_q;
    abort_d     = abort_q;
    dir_d       = dir_q;
    abdone_d    = 1'b0;
    curaddr_d   = curaddr_q;
    remaining_d = remaining_q;
    ptr_d       = ptr_q;
    bufidx_d    = bufidx_q;
    cnt_d       = cnt_q;
`ifdef RL11_DMA_BURST_EN
    tenure_d    = (state_q == S_IDLE) ? 2'd0 : tenure_q;
`endif
    if (armwrite && armwaddr == 2'd2 && !busy_q) remaining_d = armwdata[8:0];
    if (armwrite && armwaddr == 2'd3) ptr_d = arm_buf_we ? arm_ptr + PW'(1) : arm_ptr;
    case (state_q)
      S_IDLE: if (start) begin
        busy_d    = 1'b1;
        nxm_d     = 1'b0;
        abort_d   = 1'b0;
        dir_d     = armwdata[30];
        curaddr_d = {armwdata[17:1], 1'b0};
        bufidx_d  = '0;
        state_d   = (remaining_q == 9'd0) ? S_DONE : S_REQ;
      end
      S_REQ:  if (npg_in_h) state_d = S_SACK;
      S_SACK: if (!npg_in_h && !bbsy_in_h && !ssyn_in_h) state_d = S_WAITBUS;
      S_WAITBUS: begin
        cnt_d   = 8'd0;
        state_d = S_DESKEW;
      end
      S_DESKEW: begin
        if (cnt_q == 8'd1) begin
          cnt_d   = 8'd0;
          state_d = S_MSYN;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_MSYN: begin
        if (ssyn_in_h) state_d = S_LATCH;
        else if (cnt_q == NXMTIMEOUT - 8'd1) begin
          nxm_d   = 1'b1;
          state_d = S_END;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_LATCH: state_d = S_END;
      S_END:   if (!ssyn_in_h) state_d = S_NEXT;
      S_NEXT: begin
        curaddr_d   = curaddr_q + 18'd2;
        bufidx_d    = bufidx_q + PW'(1);
        remaining_d = remaining_q - 9'd1;
        if (last || nxm_q) state_d = S_DONE;
        else if (burst_cont) state_d = S_WAITBUS;
        else state_d = S_REQ;
`ifdef RL11_DMA_BURST_EN
        tenure_d = burst_cont ? tenure_q + 2'd1 : 2'd0;
`endif
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // INIT overrides everything, including a start in the same clock
    if (init_in_h) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      abort_d  = 1'b1;
      abdone_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      nxm_q       <= 1'b0;
      abort_q     <= 1'b0;
      dir_q       <= 1'b0;
      abdone_q    <= 1'b0;
      curaddr_q   <= '0;
      remaining_q <= '0;
      ptr_q       <= '0;
      bufidx_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      nxm_q       <= nxm_d;
      abort_q     <= abort_d;
      dir_q       <= dir_d;
      abdone_q    <= abdone_d;
      curaddr_q   <= curaddr_d;
      remaining_q <= remaining_d;
      ptr_q       <= ptr_d;
      bufidx_q    <= bufidx_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef RL11_DMA_BURST_EN
  always_ff @(posedge CLOCK) begin
    if (RESET) tenure_q <= 2'd0;
    else       tenure_q <= tenure_d;
  end
`endif

  // Bus DATI capture takes priority over an ARM buffer write in the same clock
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      if (latch_we) buf_mem[bufidx_q] <= d_in_h;
      else if (arm_buf_we) buf_mem[arm_ptr] <= armwdata[15:0];
    end
  end

  assign drive      = state_q inside {S_WAITBUS, S_DESKEW, S_MSYN, S_LATCH, S_END};
  assign npr_out_h  = (state_q == S_REQ);
  assign sack_out_h = (state_q == S_SACK);
  assign bbsy_out_h = drive || (state_q == S_NEXT && burst_cont);
  assign msyn_out_h = (state_q == S_MSYN) || (state_q == S_LATCH);
  assign a_out_h    = drive ? curaddr_q : 18'd0;
  assign c_out_h    = drive ? {1'b0, dir_q} : 2'b00;
  assign d_out_h    = (drive && dir_q) ? buf_mem[bufidx_q] : 16'd0;
  assign done       = (state_q == S_DONE) || abdone_q;

  always_comb begin
    armrdata = 32'h0;
    case (armraddr)
      2'd0: armrdata = 32'h52442001;
      2'd1: armrdata = {busy_q, nxm_q, abort_q, 11'b0, curaddr_q};
      2'd2: armrdata = {23'b0, remaining_q};
      2'd3: armrdata = {8'b0, 8'(ptr_q), buf_mem[ptr_q]};
      default: armrdata = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_rl11_dma.sv
// Bench for rl11_dma: arbiter and memory slave models, bus-cycle scoreboard checked on msyn rise.
module tb_rl11_dma;
  logic        CLOCK = 0, RESET = 1;
  logic        armwrite = 0;
  logic [1:0]  armwaddr = 0, armraddr = 0;
  logic [31:0] armwdata = 0, armrdata;
  logic        init_in_h = 0, npr_out_h, npg_in_h = 0, sack_out_h;
  logic        bbsy_in_h = 0, bbsy_out_h, ssyn_in_h = 0, msyn_out_h;
  logic [17:0] a_out_h;
  logic [1:0]  c_out_h;
  logic [15:0] d_out_h, d_in_h = 0;
  logic        done;

  rl11_dma dut (
    .CLOCK(CLOCK), .RESET(RESET), .armwrite(armwrite), .armwaddr(armwaddr),
    .armraddr(armraddr), .armwdata(armwdata), .armrdata(armrdata),
    .init_in_h(init_in_h), .npr_out_h(npr_out_h), .npg_in_h(npg_in_h),
    .sack_out_h(sack_out_h), .bbsy_in_h(bbsy_in_h), .bbsy_out_h(bbsy_out_h),
    .ssyn_in_h(ssyn_in_h), .msyn_out_h(msyn_out_h), .a_out_h(a_out_h),
    .c_out_h(c_out_h), .d_out_h(d_out_h), .d_in_h(d_in_h), .done(done)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [17:0] a;
    logic [1:0]  c;
    logic [15:0] d;
  } cyc_t;

  cyc_t exp_q[$];
  cyc_t e;
  int   n_chk = 0, n_err = 0;
  int   npr_cnt = 0, done_cnt = 0, msyn_run = 0, msyn_len = 0, sdly = 0;
  logic msyn_prev = 0, npr_prev = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dati_val(input logic [17:0] a);
    if (a == 18'o2000) return 16'o123456;
    if (a == 18'o2002) return 16'o654321;
    return a[15:0] ^ 16'h5a5a;
  endfunction

  // Grant after a request, withdraw once selection is acknowledged
  always @(negedge CLOCK) begin
    if (sack_out_h || !npr_out_h) npg_in_h = 0;
    else npg_in_h = 1;
  end

  // Memory slave; nothing answers in 760000-767777
  always @(negedge CLOCK) begin
    if (msyn_out_h && a_out_h[17:12] != 6'o76) begin
      if (sdly >= 2) begin
        ssyn_in_h = 1;
        d_in_h    = dati_val(a_out_h);
      end
      sdly++;
    end else begin
      ssyn_in_h = 0;
      d_in_h    = 0;
      sdly      = 0;
    end
  end

  always @(negedge CLOCK) begin
    if (done) done_cnt++;
    if (npr_out_h && !npr_prev) npr_cnt++;
    npr_prev = npr_out_h;
    if (msyn_out_h) begin
      if (!msyn_prev) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '1;
        chk("cyc_addr", {14'b0, a_out_h}, {14'b0, e.a});
        chk("cyc_ctrl", {30'b0, c_out_h}, {30'b0, e.c});
        chk("cyc_data", {16'b0, d_out_h}, {16'b0, e.d});
      end
      msyn_run++;
    end else if (msyn_prev) begin
      msyn_len = msyn_run;
      msyn_run = 0;
    end
    msyn_prev = msyn_out_h;
  end

  task automatic arm_wr(input logic [1:0] r, input logic [31:0] v);
    @(negedge CLOCK);
    armwaddr = r; armwdata = v; armwrite = 1;
    @(negedge CLOCK);
    armwrite = 0;
  endtask

  task automatic arm_rd(input logic [1:0] r, output logic [31:0] v);
    @(negedge CLOCK);
    armraddr = r;
    #1 v = armrdata;
  endtask

  task automatic buf_wr(input logic [7:0] idx, input logic [15:0] v);
    arm_wr(2'd3, {1'b1, 7'b0, idx, v});
  endtask

  task automatic run(input string tag, input logic dir, input logic [17:0] addr, input int budget);
    int base;
    base = done_cnt;
    arm_wr(2'd1, {1'b1, dir, 12'b0, addr});
    for (int i = 0; i < budget && done_cnt == base; i++) begin
      @(negedge CLOCK); #2;
    end
    repeat (3) @(negedge CLOCK);
    #2 chk(tag, done_cnt - base, 1);
  endtask

  initial begin
    logic [31:0] r;
    int base, nb;
    repeat (3) @(negedge CLOCK);
    RESET = 0;
    chk("rst_ctl", {27'b0, npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, done}, 0);
    chk("rst_bus", {c_out_h, a_out_h, 12'b0} | {16'b0, d_out_h}, 0);
    arm_rd(2'd0, r); chk("id_reg", r, 32'h52442001);
    arm_rd(2'd1, r); chk("rst_reg1", r, 0);
    arm_rd(2'd2, r); chk("rst_reg2", r, 0);
    arm_rd(2'd3, r); chk("rst_ptr", {16'b0, r[31:16]}, 0);

    // DATO three words
    buf_wr(8'd0, 16'o111); buf_wr(8'd1, 16'o222); buf_wr(8'd2, 16'o333);
    arm_wr(2'd2, 32'd3);
    exp_q.push_back({18'o1000, 2'b01, 16'o111});
    exp_q.push_back({18'o1002, 2'b01, 16'o222});
    exp_q.push_back({18'o1004, 2'b01, 16'o333});
    run("dato_done", 1'b1, 18'o1000, 300);
    arm_rd(2'd1, r); chk("dato_reg1", r, {3'b000, 11'b0, 18'o1006});
    arm_rd(2'd2, r); chk("dato_rem", r, 0);
    chk("dato_sb", exp_q.size(), 0);

    // DATI two words
    arm_wr(2'd2, 32'd2);
    exp_q.push_back({18'o2000, 2'b00, 16'h0});
    exp_q.push_back({18'o2002, 2'b00, 16'h0});
    run("dati_done", 1'b0, 18'o2000, 300);
    arm_wr(2'd3, {8'h00, 8'd1, 16'h0});
    arm_rd(2'd3, r); chk("dati_buf1", r, {8'h0, 8'd1, 16'o654321});
    arm_wr(2'd3, 32'h0);
    arm_rd(2'd3, r); chk("dati_buf0", r, {16'h0, 16'o123456});

    // NXM
    arm_wr(2'd2, 32'd3);
    exp_q.push_back({18'o760000, 2'b00, 16'h0});
    run("nxm_done", 1'b0, 18'o760000, 500);
    chk("nxm_msyn_len", msyn_len, 150);
    arm_rd(2'd1, r); chk("nxm_reg1", r, {3'b010, 11'b0, 18'o760002});
    arm_rd(2'd2, r); chk("nxm_rem", r, 2);
    chk("nxm_bus_rel", {12'b0, bbsy_out_h, msyn_out_h, a_out_h}, 0);

    // Address wrap
    arm_wr(2'd2, 32'd2);
    exp_q.push_back({18'o777776, 2'b01, 16'o123456});
    exp_q.push_back({18'o000000, 2'b01, 16'o654321});
    run("wrap_done", 1'b1, 18'o777776, 300);
    arm_rd(2'd1, r); chk("wrap_reg1", r, {3'b000, 11'b0, 18'o000002});

    // INIT during MSYN
    arm_wr(2'd2, 32'd1);
    exp_q.push_back({18'o760000, 2'b00, 16'h0});
    base = done_cnt;
    arm_wr(2'd1, {2'b10, 12'b0, 18'o760000});
    for (int i = 0; i < 60 && !msyn_out_h; i++) @(negedge CLOCK);
    chk("abort_msyn_seen", {31'b0, msyn_out_h}, 1);
    repeat (5) @(negedge CLOCK);
    init_in_h = 1;
    @(negedge CLOCK);
    init_in_h = 0;
    chk("abort_bus", {12'b0, msyn_out_h, bbsy_out_h, a_out_h}, 0);
    chk("abort_done", {31'b0, done}, 1);
    arm_rd(2'd1, r); chk("abort_reg1", r, {3'b001, 11'b0, 18'o760000});
    repeat (3) @(negedge CLOCK);
    #2 chk("abort_pulses", done_cnt - base, 1);

    // Start together with INIT: INIT wins
    arm_wr(2'd2, 32'd1);
    nb = npr_cnt;
    @(negedge CLOCK);
    armwaddr = 2'd1; armwdata = {2'b11, 12'b0, 18'o3000}; armwrite = 1; init_in_h = 1;
    @(negedge CLOCK);
    armwrite = 0; init_in_h = 0;
    repeat (10) @(negedge CLOCK);
    arm_rd(2'd1, r); chk("si_reg1", r, {3'b001, 11'b0, 18'o760000});
    chk("si_npr", npr_cnt - nb, 0);

    // wc = 0
    arm_wr(2'd2, 32'd0);
    nb = npr_cnt; base = done_cnt;
    arm_wr(2'd1, {2'b11, 12'b0, 18'o4000});
    #2 chk("wc0_done_next", {31'b0, done}, 1);
    repeat (5) @(negedge CLOCK);
    #2 chk("wc0_pulses", done_cnt - base, 1);
    chk("wc0_npr", npr_cnt - nb, 0);
    arm_rd(2'd1, r); chk("wc0_reg1", r, {3'b000, 11'b0, 18'o4000});

    // Six words: one NPR per word, or two tenures when bursting
    for (int i = 0; i < 6; i++) buf_wr(8'(i), 16'(16'o1000 + i));
    arm_wr(2'd2, 32'd6);
    for (int i = 0; i < 6; i++) exp_q.push_back({18'(18'o10000 + 2 * i), 2'b01, 16'(16'o1000 + i)});
    nb = npr_cnt;
    run("wc6_done", 1'b1, 18'o10000, 600);
`ifdef RL11_DMA_BURST_EN
    chk("wc6_npr_burst", npr_cnt - nb, 2);
`else
    chk("wc6_npr", npr_cnt - nb, 6);
`endif
    arm_rd(2'd1, r); chk("wc6_reg1", r, {3'b000, 11'b0, 18'o10014});
    chk("end_sb", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
